// File: rtl/rv32i_mc_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// memory-wait timeout, sticky HALT/FAULT and a retired-instruction counter.
module rv32i_mc_sequencer #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned BYPASS_MEM  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             halt,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned OP_W   = 7;
  localparam int unsigned WAIT_W = 8;

  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic              BYPASS    = (BYPASS_MEM != 0);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                retire_c;

  logic                op_is_load_c;
  logic                op_is_store_c;
  logic                op_is_branch_c;
  logic                op_is_mem_c;
  logic                wait_hit_c;
  logic                opcode_legal_c;

  // Legal RV32I opcodes that may proceed to EXECUTE (SYSTEM is handled apart)
  always_comb begin
    unique case (opcode)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_JALR, OP_STORE,
      OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC: opcode_legal_c = 1'b1;
      default:                             opcode_legal_c = 1'b0;
    endcase
  end

  assign op_is_load_c   = (op_q == OP_LOAD);
  assign op_is_store_c  = (op_q == OP_STORE);
  assign op_is_branch_c = (op_q == OP_BRANCH);
  assign op_is_mem_c    = op_is_load_c | op_is_store_c;
  assign wait_hit_c     = (wait_q == WAIT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      instret <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      if (retire_c) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

  assign state = state_q;

  // Next-state, wait counter and retirement
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = wait_q;
    retire_c = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (en) begin
          if (mem_ready) begin
            state_d = S_DECODE;
          end else if (wait_hit_c) begin
            state_d = S_FAULT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (opcode_legal_c) begin
          state_d = S_EXECUTE;
        end else if (opcode == OP_SYSTEM) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_EXECUTE: begin
        wait_d = '0;
        if (op_is_branch_c) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (op_is_mem_c || !BYPASS) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (!op_is_mem_c) begin
          state_d = S_WRITEBACK;
        end else if (mem_ready) begin
          if (op_is_store_c) begin
            retire_c = 1'b1;
            wait_d   = '0;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_hit_c) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        retire_c = 1'b1;
        wait_d   = '0;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Mealy strobes, forced low while reset is asserted
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    rf_we   = 1'b0;
    halt    = 1'b0;
    fault   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = en;
        ir_we   = en & mem_ready;
      end
      S_EXECUTE: begin
        pc_we = op_is_branch_c;
      end
      S_MEM: begin
        if (op_is_mem_c) begin
          mem_req = 1'b1;
          mem_we  = op_is_store_c;
          pc_we   = op_is_store_c & mem_ready;
        end
      end
      S_WRITEBACK: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
      end
      S_HALT:  halt  = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      rf_we   = 1'b0;
      halt    = 1'b0;
      fault   = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32i_mc_sequencer.sv
// Bench for rv32i_mc_sequencer: two configurations share random stimulus and are
// checked every cycle against a route-based instruction model, plus literal traces.
module tb_rv32i_mc_sequencer;

  localparam logic [6:0] ADDI   = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYS    = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] opcode;
  logic       mem_ready;

  logic [2:0]  state_a, state_b;
  logic        mem_req_a, mem_we_a, ir_we_a, pc_we_a, rf_we_a, halt_a, fault_a;
  logic        mem_req_b, mem_we_b, ir_we_b, pc_we_b, rf_we_b, halt_b, fault_b;
  logic [31:0] instret_a;
  logic [3:0]  instret_b;

  always #5 clk = ~clk;

  rv32i_mc_sequencer #(.CNT_W(32), .MEM_TIMEOUT(4), .BYPASS_MEM(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .state(state_a), .mem_req(mem_req_a), .mem_we(mem_we_a), .ir_we(ir_we_a),
    .pc_we(pc_we_a), .rf_we(rf_we_a), .halt(halt_a), .fault(fault_a),
    .instret(instret_a));

  rv32i_mc_sequencer #(.CNT_W(4), .MEM_TIMEOUT(6), .BYPASS_MEM(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .state(state_b), .mem_req(mem_req_b), .mem_we(mem_we_b), .ir_we(ir_we_b),
    .pc_we(pc_we_b), .rf_we(rf_we_b), .halt(halt_b), .fault(fault_b),
    .instret(instret_b));

  int vectors = 0;
  int miscompares = 0;

  // Per-configuration model: current phase plus the phases still ahead for this instruction
  int          to_lim [2] = '{4, 6};
  int          bypass [2] = '{1, 0};
  int unsigned cmask  [2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  int          cur    [2];
  int          waits  [2];
  int          rt     [2][2];
  int          rlen   [2];
  int          rpos   [2];
  bit          memop  [2];
  bit          storeop[2];
  int unsigned cnt    [2];

  logic [2:0]  rec_sa[$];
  logic [2:0]  rec_sb[$];
  logic [6:0]  rec_xa[$];
  int unsigned rec_ia[$];

  function automatic logic [6:0] strobes(input int k);
    if (k == 0) return {mem_req_a, mem_we_a, ir_we_a, pc_we_a, rf_we_a, halt_a, fault_a};
    return {mem_req_b, mem_we_b, ir_we_b, pc_we_b, rf_we_b, halt_b, fault_b};
  endfunction

  function automatic int unsigned act_state(input int k);
    return (k == 0) ? int'(state_a) : int'(state_b);
  endfunction

  function automatic int unsigned act_instret(input int k);
    return (k == 0) ? instret_a : {28'd0, instret_b};
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cur[k] = 0; waits[k] = 0; rlen[k] = 0; rpos[k] = 0;
      memop[k] = 1'b0; storeop[k] = 1'b0; cnt[k] = 0;
    end
  endtask

  // Ends the current phase: next planned phase, or retire and go back to fetch
  task automatic finish_phase(input int k, output bit retired);
    waits[k] = 0;
    if (rpos[k] == rlen[k]) begin
      retired = 1'b1;
      cnt[k]  = cnt[k] + 1;
      cur[k]  = 0;
    end else begin
      retired = 1'b0;
      cur[k]  = rt[k][rpos[k]];
      rpos[k] = rpos[k] + 1;
    end
  endtask

  task automatic count_wait(input int k);
    waits[k] = waits[k] + 1;
    if (waits[k] >= to_lim[k]) cur[k] = 6;
  endtask

  task automatic model_cycle(input int k, output logic [6:0] ex);
    bit mr = 0, mw = 0, ir = 0, pw = 0, rw = 0, hl = 0, ft = 0;
    bit r;
    bit e = en;
    bit rdy = mem_ready;
    case (cur[k])
      0: begin
        mr = e; ir = e & rdy;
        if (e) begin
          if (rdy) cur[k] = 1;
          else count_wait(k);
        end
      end
      1: begin
        memop[k] = 1'b0; storeop[k] = 1'b0; rpos[k] = 0; rlen[k] = 0; cur[k] = 2;
        case (opcode)
          7'b1100011: ;
          7'b0000011: begin rt[k][0] = 3; rt[k][1] = 4; rlen[k] = 2; memop[k] = 1'b1; end
          7'b0100011: begin rt[k][0] = 3; rlen[k] = 1; memop[k] = 1'b1; storeop[k] = 1'b1; end
          7'b0110011, 7'b0010011, 7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111: begin
            if (bypass[k] != 0) begin rt[k][0] = 4; rlen[k] = 1; end
            else begin rt[k][0] = 3; rt[k][1] = 4; rlen[k] = 2; end
          end
          7'b1110011: cur[k] = 5;
          default:    cur[k] = 6;
        endcase
      end
      2: begin finish_phase(k, r); pw = r; end
      3: begin
        if (memop[k]) begin
          mr = 1; mw = storeop[k];
          if (rdy) begin finish_phase(k, r); pw = r; end
          else count_wait(k);
        end else begin
          finish_phase(k, r);
        end
      end
      4: begin rw = 1; finish_phase(k, r); pw = r; end
      5: hl = 1;
      default: ft = 1;
    endcase
    ex = {mr, mw, ir, pw, rw, hl, ft};
  endtask

  task automatic check_cycle();
    logic [6:0] ex;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("state[%0d]", k), act_state(k), cur[k]);
      chk($sformatf("instret[%0d]", k), act_instret(k), cnt[k] & cmask[k]);
      model_cycle(k, ex);
      chk($sformatf("strobes[%0d]", k), int'(strobes(k)), int'(ex));
    end
  endtask

  // One clock: inputs driven just after posedge, outputs checked on negedge
  task automatic cyc(input logic e, input logic [6:0] op, input logic r);
    en = e; opcode = op; mem_ready = r;
    @(negedge clk);
    rec_sa.push_back(state_a);
    rec_sb.push_back(state_b);
    rec_xa.push_back(strobes(0));
    rec_ia.push_back(instret_a);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    rec_sa.delete(); rec_sb.delete(); rec_xa.delete(); rec_ia.delete();
  endtask

  // Asynchronous reset between edges; outputs must drop before any clock edge
  task automatic do_reset();
    rst = 1'b1; en = 1'b1; mem_ready = 1'b1; opcode = 7'($urandom);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_state[%0d]", k), act_state(k), 0);
      chk($sformatf("rst_instret[%0d]", k), act_instret(k), 0);
      chk($sformatf("rst_strobes[%0d]", k), int'(strobes(k)), 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_rec();
  endtask

  task automatic chk_trace_a(input string name, input int exp[]);
    for (int i = 0; i < exp.size(); i++) chk($sformatf("%s_a[%0d]", name, i), rec_sa[i], exp[i]);
  endtask

  function automatic logic [6:0] rand_opcode();
    logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                             7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
    int r = int'($urandom_range(0, 39));
    if (r == 0) return SYS;
    if (r == 1) return 7'($urandom);
    return legal[r % 9];
  endfunction

  initial begin
    logic [6:0] x;
    do_reset();

    // ADDI: A bypasses MEM, B traverses it
    repeat (6) cyc(1'b1, ADDI, 1'b1);
    chk_trace_a("addi", '{0, 1, 2, 4, 0, 1});
    for (int i = 0; i < 6; i++) chk($sformatf("addi_b[%0d]", i), rec_sb[i], (i == 5) ? 0 : i);
    for (int i = 0; i < 5; i++) begin
      x = rec_xa[i];
      chk($sformatf("addi_rfwe[%0d]", i), x[2], (i == 3) ? 1 : 0);
      chk($sformatf("addi_pcwe[%0d]", i), x[3], (i == 3) ? 1 : 0);
    end
    chk("addi_instret_before", rec_ia[3], 0);
    chk("addi_instret_after", rec_ia[4], 1);

    // Store, memory ready immediately
    do_reset();
    repeat (5) cyc(1'b1, STORE, 1'b1);
    chk_trace_a("store", '{0, 1, 2, 3, 0});
    x = rec_xa[3];
    chk("store_memwe", x[5], 1);
    for (int i = 0; i < 5; i++) begin
      x = rec_xa[i];
      chk($sformatf("store_rfwe[%0d]", i), x[2], 0);
    end
    chk("store_instret", rec_ia[4], 1);

    // Load with three not-ready MEM cycles
    do_reset();
    repeat (3) cyc(1'b1, LOAD, 1'b1);
    repeat (3) cyc(1'b1, LOAD, 1'b0);
    repeat (3) cyc(1'b1, LOAD, 1'b1);
    chk_trace_a("load", '{0, 1, 2, 3, 3, 3, 3, 4, 0});
    for (int i = 3; i < 7; i++) begin
      x = rec_xa[i];
      chk($sformatf("load_memwe[%0d]", i), x[5], 0);
    end
    x = rec_xa[7];
    chk("load_rfwe", x[2], 1);
    chk("load_instret", rec_ia[8], 1);

    // Fetch timeout (A: 4 waits), fault sticks
    do_reset();
    repeat (26) cyc(1'b1, ADDI, 1'b0);
    chk("tmo_before", rec_sa[3], 0);
    for (int i = 4; i < 26; i++) begin
      x = rec_xa[i];
      chk($sformatf("tmo_state[%0d]", i), rec_sa[i], 6);
      chk($sformatf("tmo_fault[%0d]", i), x[0], 1);
    end
    chk("tmo_b_before", rec_sb[5], 0);
    chk("tmo_b_after", rec_sb[6], 6);

    // Ready in the last allowed wait cycle wins
    do_reset();
    repeat (3) cyc(1'b1, ADDI, 1'b0);
    repeat (2) cyc(1'b1, ADDI, 1'b1);
    chk("ready_wins", rec_sa[4], 1);

    // ECALL/EBREAK halts without retiring; opcode 0 faults
    do_reset();
    repeat (4) cyc(1'b1, SYS, 1'b1);
    chk_trace_a("sys", '{0, 1, 5, 5});
    x = rec_xa[2];
    chk("sys_halt", x[1], 1);
    chk("sys_instret", rec_ia[3], 0);
    do_reset();
    repeat (4) cyc(1'b1, 7'b0000000, 1'b1);
    chk_trace_a("ill", '{0, 1, 6, 6});
    x = rec_xa[2];
    chk("ill_fault", x[0], 1);

    // Reset mid-MEM, then en=0 holds FETCH without requests
    do_reset();
    repeat (3) cyc(1'b1, STORE, 1'b1);
    repeat (2) cyc(1'b1, STORE, 1'b0);
    chk("pre_rst_mem", rec_sa[4], 3);
    do_reset();
    repeat (3) cyc(1'b0, LOAD, 1'b1);
    for (int i = 0; i < 3; i++) begin
      x = rec_xa[i];
      chk($sformatf("idle_state[%0d]", i), rec_sa[i], 0);
      chk($sformatf("idle_memreq[%0d]", i), x[6], 0);
    end

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ((cur[0] >= 5 && cur[1] >= 5) || $urandom_range(0, 299) == 0) do_reset();
      cyc(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, rand_opcode(),
          ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0);
      if (rec_sa.size() > 64) clear_rec();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_sequencer.md
RV32I_MC_SEQUENCER -- requirements
Module: rv32i_mc_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, max memory-wait cycles per access (legal range 1..255).
REQ-003 SHALL have parameter BYPASS_MEM, default 1; 1 = non-memory instructions skip MEM, 0 = all instructions traverse MEM.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 en  in  1  run enable, sampled in FETCH only.
REQ-008 opcode  in  7  RV32I opcode field from instruction register.
REQ-009 mem_ready  in  1  memory completes current request this cycle.
REQ-010 state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, FAULT=6.
REQ-011 mem_req  out  1  memory request active.
REQ-012 mem_we  out  1  memory request is a write.
REQ-013 ir_we  out  1  instruction register load strobe.
REQ-014 pc_we  out  1  PC update strobe.
REQ-015 rf_we  out  1  register-file write strobe.
REQ-016 halt  out  1  ECALL/EBREAK reached; sticky.
REQ-017 fault  out  1  illegal opcode or memory timeout; sticky.
REQ-018 instret  out  CNT_W  retired-instruction count.

Function
REQ-019 FETCH: mem_req=en; en=0 -> hold FETCH, no wait counting; ir_we=mem_ready&en (combinational); mem_ready&en -> DECODE.
REQ-020 DECODE: capture opcode into internal op_q; legal set {0110011,0010011,0000011,1100111,0100011,1100011,1101111,0110111,0010111} -> EXECUTE; 1110011 -> HALT; anything else -> FAULT.
REQ-021 EXECUTE, op_q=1100011 (branch): pc_we=1, instret+1, -> FETCH.
REQ-022 EXECUTE, op_q load (0000011) or store (0100011): -> MEM.
REQ-023 EXECUTE, other opcodes: -> WRITEBACK if BYPASS_MEM=1, else -> MEM.
REQ-024 MEM, load/store: mem_req=1, mem_we=1 only for store; wait for mem_ready; store -> pc_we=1, instret+1, -> FETCH on that cycle; load -> WRITEBACK.
REQ-025 MEM, non-memory opcode (BYPASS_MEM=0 only): mem_req=0, one cycle, -> WRITEBACK.
REQ-026 WRITEBACK: rf_we=1, pc_we=1, instret+1, -> FETCH.
REQ-027 Wait counter SHALL clear on entry to FETCH/MEM, increment each cycle with mem_req=1 and mem_ready=0; mem_ready=0 in the MEM_TIMEOUT-th such cycle -> FAULT.
REQ-028 mem_ready=1 in the final allowed wait cycle SHALL complete normally (ready wins over timeout).
REQ-029 HALT and FAULT SHALL be terminal until reset; all strobes 0 there; halt=1 only in HALT, fault=1 only in FAULT.
REQ-030 instret SHALL wrap modulo 2^CNT_W; never increments in HALT/FAULT or for ECALL/EBREAK.
REQ-031 Strobes SHALL be Mealy (decoded from state, op_q, mem_ready, en); state, op_q, wait counter, instret SHALL be registered.
REQ-032 Best-case latency: ALU op 4 cycles (BYPASS_MEM=1), 5 (BYPASS_MEM=0); branch 3; store/load 4/5 with mem_ready=1.

Reset
REQ-033 rst=1 SHALL immediately force state=FETCH, instret=0, op_q=0, wait counter=0, all 1-bit outputs 0 (outputs gated by rst), independent of clk.
REQ-034 Reset asserted mid-instruction SHALL abort it with no strobe and no instret increment; first post-reset cycle is FETCH.

Verification
REQ-035 ADDI 0010011, mem_ready=1, BYPASS_MEM=1 -> state 0,1,2,4,0; rf_we=pc_we=1 in state 4 only; instret 0->1.
REQ-036 Load 0000011, mem_ready low 3 MEM cycles -> MEM lasts 4 cycles, mem_we=0, then WRITEBACK rf_we=1; instret+1.
REQ-037 Store 0100011, mem_ready=1 -> state 0,1,2,3,0; mem_we=1 in MEM, rf_we never 1; instret+1.
REQ-038 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> state=6 after 4 wait cycles, fault=1 held 20+ cycles; ready on 4th cycle -> DECODE instead.
REQ-039 Opcode 1110011 -> HALT, halt=1, instret unchanged; opcode 0000000 -> FAULT, fault=1.
REQ-040 rst pulsed mid-MEM between clock edges -> state=0, all outputs 0, instret=0 before next edge; en=0 then holds FETCH with mem_req=0.
